// File: rtl/operand2_sel_stage.sv
// EX-stage operand-2 selector with MEM/WB forwarding and a registered valid/ready output.
// Optional macro OP2_FWD_COUNT_EN builds a saturating count of forwarded beats on fwd_count.
module operand2_sel_stage #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned REG_AW  = 3,
  parameter int unsigned CONST_A = 1,
  parameter int unsigned CONST_B = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op2_sel,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic [DATA_W-1:0] rout2,
  input  logic [DATA_W-1:0] imm,
  input  logic              fwd_mem_en,
  input  logic [REG_AW-1:0] fwd_mem_addr,
  input  logic [DATA_W-1:0] fwd_mem_data,
  input  logic              fwd_wb_en,
  input  logic [REG_AW-1:0] fwd_wb_addr,
  input  logic [DATA_W-1:0] fwd_wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] op2,
  output logic [1:0]        fwd_hit,
  output logic              sel_err,
  output logic [15:0]       fwd_count
);

  localparam logic [DATA_W-1:0] CONST_A_W = DATA_W'(CONST_A);
  localparam logic [DATA_W-1:0] CONST_B_W = DATA_W'(CONST_B);

  localparam logic [1:0] HIT_NONE = 2'b00;
  localparam logic [1:0] HIT_MEM  = 2'b01;
  localparam logic [1:0] HIT_WB   = 2'b10;

  logic              accept;
  logic              mem_match;
  logic              wb_match;
  logic [DATA_W-1:0] next_op2;
  logic [1:0]        next_hit;
  logic              next_illegal;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Register 0 is hardwired, so a write to it must never be forwarded.
  assign mem_match = fwd_mem_en && (fwd_mem_addr == rs2_addr) && (rs2_addr != '0);
  assign wb_match  = fwd_wb_en  && (fwd_wb_addr  == rs2_addr) && (rs2_addr != '0);

  always_comb begin
    next_op2     = '0;
    next_hit     = HIT_NONE;
    next_illegal = 1'b0;
    case (op2_sel)
      3'b000: next_op2 = '0;
      3'b001: begin
        if (mem_match) begin
          next_op2 = fwd_mem_data;
          next_hit = HIT_MEM;
        end else if (wb_match) begin
          next_op2 = fwd_wb_data;
          next_hit = HIT_WB;
        end else begin
          next_op2 = rout2;
        end
      end
      3'b010:  next_op2 = CONST_A_W;
      3'b011:  next_op2 = CONST_B_W;
      3'b100:  next_op2 = imm;
      default: next_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      op2       <= '0;
      fwd_hit   <= HIT_NONE;
      sel_err   <= 1'b0;
    end else begin
      if (accept) begin
        op2     <= next_op2;
        fwd_hit <= next_hit;
        if (next_illegal) begin
          sel_err <= 1'b1;
        end
      end
      // Flush wins: a beat accepted in the same cycle is dropped on the floor.
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef OP2_FWD_COUNT_EN
  logic [15:0] fwd_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_count_q <= '0;
    end else if (accept && !flush && (next_hit != HIT_NONE) && (fwd_count_q != 16'hFFFF)) begin
      fwd_count_q <= fwd_count_q + 16'd1;
    end
  end

  assign fwd_count = fwd_count_q;
`else
  assign fwd_count = '0;
`endif

endmodule

// File: tb/tb_operand2_sel_stage.sv
// Scoreboard bench for operand2_sel_stage: directed beats queue expectations, a monitor checks them.
// Expects fwd_count to follow the OP2_FWD_COUNT_EN setting used for the build.
module tb_operand2_sel_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op2_sel;
  logic [2:0]  rs2_addr;
  logic [15:0] rout2;
  logic [15:0] imm;
  logic        fwd_mem_en;
  logic [2:0]  fwd_mem_addr;
  logic [15:0] fwd_mem_data;
  logic        fwd_wb_en;
  logic [2:0]  fwd_wb_addr;
  logic [15:0] fwd_wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] op2;
  logic [1:0]  fwd_hit;
  logic        sel_err;
  logic [15:0] fwd_count;

  typedef struct packed {
    logic [15:0] op2;
    logic [1:0]  hit;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;

`ifdef OP2_FWD_COUNT_EN
  localparam logic [15:0] EXP_COUNT_FINAL = 16'd4;
`else
  localparam logic [15:0] EXP_COUNT_FINAL = 16'd0;
`endif

  operand2_sel_stage #(
    .DATA_W (16),
    .REG_AW (3),
    .CONST_A(1),
    .CONST_B(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op2_sel     (op2_sel),
    .rs2_addr    (rs2_addr),
    .rout2       (rout2),
    .imm         (imm),
    .fwd_mem_en  (fwd_mem_en),
    .fwd_mem_addr(fwd_mem_addr),
    .fwd_mem_data(fwd_mem_data),
    .fwd_wb_en   (fwd_wb_en),
    .fwd_wb_addr (fwd_wb_addr),
    .fwd_wb_data (fwd_wb_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .op2         (op2),
    .fwd_hit     (fwd_hit),
    .sel_err     (sel_err),
    .fwd_count   (fwd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Presents one beat, waits (bounded) for in_ready, queues its expectation unless flushed.
  task automatic applyStimulus(
    input logic [2:0]  sel,
    input logic [2:0]  rs2,
    input logic [15:0] rdata,
    input logic [15:0] imm_v,
    input logic        mem_en,
    input logic [15:0] mem_data,
    input logic        wb_en,
    input logic [15:0] wb_data,
    input logic        do_flush,
    input logic [15:0] exp_op2,
    input logic [1:0]  exp_hit
  );
    bit   done;
    exp_t e;
    done         = 1'b0;
    in_valid     = 1'b1;
    op2_sel      = sel;
    rs2_addr     = rs2;
    rout2        = rdata;
    imm          = imm_v;
    fwd_mem_en   = mem_en;
    fwd_mem_addr = rs2;
    fwd_mem_data = mem_data;
    fwd_wb_en    = wb_en;
    fwd_wb_addr  = rs2;
    fwd_wb_data  = wb_data;
    flush        = do_flush;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (!do_flush) begin
          e.op2 = exp_op2;
          e.hit = exp_hit;
          sb_q.push_back(e);
        end
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for 50 cycles, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    flush      = 1'b0;
    fwd_mem_en = 1'b0;
    fwd_wb_en  = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every consumed beat is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_beat: got op2=%0h with empty scoreboard, expected no beat", op2);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("beat_op2", {16'd0, op2}, {16'd0, e.op2});
        checkOutput("beat_fwd_hit", {30'd0, fwd_hit}, {30'd0, e.hit});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    in_valid     = 1'b0;
    op2_sel      = 3'b000;
    rs2_addr     = '0;
    rout2        = '0;
    imm          = '0;
    fwd_mem_en   = 1'b0;
    fwd_mem_addr = '0;
    fwd_mem_data = '0;
    fwd_wb_en    = 1'b0;
    fwd_wb_addr  = '0;
    fwd_wb_data  = '0;
    out_ready    = 1'b1;
    idleCycles(2);
    @(negedge clk);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_op2", {16'd0, op2}, 32'd0);
    checkOutput("rst_fwd_hit", {30'd0, fwd_hit}, 32'd0);
    checkOutput("rst_sel_err", {31'd0, sel_err}, 32'd0);
    checkOutput("rst_fwd_count", {16'd0, fwd_count}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Constants, immediate and zero, back to back
    applyStimulus(3'b010, 3'd0, 16'h0000, 16'h1234, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0001, 2'b00);
    applyStimulus(3'b011, 3'd0, 16'h0000, 16'h1234, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0003, 2'b00);
    applyStimulus(3'b100, 3'd0, 16'h0000, 16'h1234, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h1234, 2'b00);
    applyStimulus(3'b000, 3'd0, 16'h5555, 16'h1234, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0000, 2'b00);

    // Forwarding priority and register 0 exclusion
    applyStimulus(3'b001, 3'd2, 16'h1111, 16'h0, 1'b1, 16'hAAAA, 1'b1, 16'hBBBB, 1'b0, 16'hAAAA, 2'b01);
    applyStimulus(3'b001, 3'd2, 16'h1111, 16'h0, 1'b0, 16'hAAAA, 1'b1, 16'hBBBB, 1'b0, 16'hBBBB, 2'b10);
    applyStimulus(3'b001, 3'd0, 16'h1111, 16'h0, 1'b1, 16'hAAAA, 1'b1, 16'hBBBB, 1'b0, 16'h1111, 2'b00);
    applyStimulus(3'b001, 3'd5, 16'h2222, 16'h0, 1'b0, 16'hAAAA, 1'b0, 16'hBBBB, 1'b0, 16'h2222, 2'b00);
    applyStimulus(3'b100, 3'd2, 16'h1111, 16'h0077, 1'b1, 16'hAAAA, 1'b1, 16'hBBBB, 1'b0, 16'h0077, 2'b00);

    // Backpressure: the held beat must stay put and block the next one
    idleCycles(3);
    out_ready = 1'b0;
    applyStimulus(3'b100, 3'd0, 16'h0, 16'h0005, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0005, 2'b00);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("hold_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("hold_op2", {16'd0, op2}, 32'h0005);
      checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    fork
      applyStimulus(3'b100, 3'd0, 16'h0, 16'h0007, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0007, 2'b00);
      begin
        idleCycles(2);
        out_ready = 1'b1;
      end
    join

    // Flush in the accept cycle drops the beat
    idleCycles(3);
    applyStimulus(3'b100, 3'd0, 16'h0, 16'hDEAD, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0, 2'b00);
    @(negedge clk);
    checkOutput("flush_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(3'b100, 3'd0, 16'h0, 16'h0042, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0042, 2'b00);

    // Illegal select: zero operand, still valid, sticky error
    applyStimulus(3'b110, 3'd0, 16'h9999, 16'h8888, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0000, 2'b00);
    @(negedge clk);
    checkOutput("illegal_out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("illegal_sel_err", {31'd0, sel_err}, 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(3'b010, 3'd0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0001, 2'b00);
    applyStimulus(3'b100, 3'd0, 16'h0, 16'h00AB, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h00AB, 2'b00);
    idleCycles(3);
    checkOutput("sel_err_sticky", {31'd0, sel_err}, 32'd1);

    rst = 1'b1;
    idleCycles(1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst2_sel_err", {31'd0, sel_err}, 32'd0);
    checkOutput("rst2_fwd_count", {16'd0, fwd_count}, 32'd0);
    @(posedge clk);
    #1;

    // Four counted forwarded beats plus one flushed forwarded beat
    applyStimulus(3'b001, 3'd3, 16'h0, 16'h0, 1'b1, 16'h0C01, 1'b0, 16'h0, 1'b0, 16'h0C01, 2'b01);
    applyStimulus(3'b001, 3'd4, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0C02, 1'b0, 16'h0C02, 2'b10);
    applyStimulus(3'b001, 3'd6, 16'h0, 16'h0, 1'b1, 16'h0C03, 1'b1, 16'h0BAD, 1'b0, 16'h0C03, 2'b01);
    applyStimulus(3'b001, 3'd7, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0C04, 1'b0, 16'h0C04, 2'b10);
    idleCycles(2);
    applyStimulus(3'b001, 3'd1, 16'h0, 16'h0, 1'b1, 16'h0C05, 1'b0, 16'h0, 1'b1, 16'h0, 2'b00);
    idleCycles(3);
    @(negedge clk);
    checkOutput("fwd_count_final", {16'd0, fwd_count}, {16'd0, EXP_COUNT_FINAL});
    checkOutput("scoreboard_drained", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/operand2_sel_stage.md
Name: operand2_sel_stage

Overview:
- Parametrised successor to the EX-stage operand-2 selector.
- Selects ALU operand 2 from the register file, two constants, an immediate, or zero.
- Resolves RAW hazards by forwarding from MEM and WB.
- Registers the result behind a valid/ready handshake; sits between the ID/EX boundary and the ALU input, with flush support for branch redirect.

Parameters:
- DATA_W, 16: operand/data width in bits.
- REG_AW, 3: register address width.
- CONST_A, 1: constant returned for select 3'b010, truncated to DATA_W.
- CONST_B, 3: constant returned for select 3'b011, truncated to DATA_W.

Ports:
- clk, input, 1: single clock, rising-edge.
- rst, input, 1: synchronous, active-high reset.
- flush, input, 1: discard output register contents.
- in_valid, input, 1: upstream beat valid.
- in_ready, output, 1: stage can accept a beat.
- op2_sel, input, 3: source select.
- rs2_addr, input, REG_AW: source register address for forwarding compare.
- rout2, input, DATA_W: register-file read data.
- imm, input, DATA_W: pre-extended immediate.
- fwd_mem_en, input, 1: MEM stage writes a register.
- fwd_mem_addr, input, REG_AW: MEM destination register.
- fwd_mem_data, input, DATA_W: MEM result.
- fwd_wb_en, input, 1: WB stage writes a register.
- fwd_wb_addr, input, REG_AW: WB destination register.
- fwd_wb_data, input, DATA_W: WB result.
- out_valid, output, 1: op2 holds a valid beat.
- out_ready, input, 1: ALU consumes the beat.
- op2, output, DATA_W: registered operand 2.
- fwd_hit, output, 2: registered forwarding source: 00 none, 01 MEM, 10 WB.
- sel_err, output, 1: sticky flag, set when an illegal select is accepted.
- fwd_count, output, 16: forwarded-beat count (see Optional Feature).

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, op2=0, fwd_hit=00, sel_err=0, fwd_count=0. Reset overrides flush and accept, and aborts any held beat.
- in_ready = !out_valid || out_ready. This is combinational and independent of flush.
- Accept occurs when in_valid && in_ready. op2, fwd_hit and out_valid=1 load at that posedge, giving 1-cycle latency.
- Hold: when out_valid && !out_ready, op2 and fwd_hit stay stable and no accept occurs.
- If out_ready && !accept, out_valid clears.
- Select decode:
  - 000: 0
  - 001: register source (forwarded)
  - 010: CONST_A
  - 011: CONST_B
  - 100: imm
  - 101–111: illegal. op2=0, the beat is still passed with out_valid=1, and sel_err is set (stays set until rst).
- Register source:
  - If fwd_mem_en && fwd_mem_addr==rs2_addr && rs2_addr!=0: use fwd_mem_data, fwd_hit=01.
  - Else if the same match holds on WB: use fwd_wb_data, fwd_hit=10.
  - Else: use rout2, fwd_hit=00.
  - MEM has priority over WB when both match.
  - Register 0 is never forwarded.
- fwd_hit is 00 for every non-register select.
- Flush: at a posedge with flush=1, out_valid=0. A beat accepted in the same cycle is discarded; the upstream handshake still completes and the beat is dropped. op2 and fwd_hit values after flush are don't-care; the bench checks them only while out_valid=1.
- Constants and imm are truncated or zero-padded to DATA_W. No sign handling occurs in this block.

Optional Feature:
- Macro: OP2_FWD_COUNT_EN.
- Defined: fwd_count increments by 1 on each accepted beat with a non-zero forwarding source.
  - Saturates at 16'hFFFF.
  - A beat discarded by same-cycle flush is not counted.
  - Cleared by rst.
- Undefined: no counter logic is built and fwd_count is tied to 0.

Test Plan:
- Reset, then op2_sel=010/011/100 with imm=16'h1234, out_ready=1 → op2 = 1, 3, 16'h1234 on successive cycles, 1-cycle latency, fwd_hit=00.
- op2_sel=001, rs2_addr=2, MEM and WB both write r2 (MEM 16'hAAAA, WB 16'hBBBB) → op2=16'hAAAA, fwd_hit=01. With MEM disabled → 16'hBBBB, fwd_hit=10. With rs2_addr=0 → rout2, fwd_hit=00.
- Hold out_ready=0 for 3 cycles after an accept of 16'h0005 → op2 stable, in_ready=0, the next beat is accepted only after out_ready=1.
- Assert flush in the same cycle as an accept → out_valid=0 next cycle; the dropped beat never appears on op2.
- op2_sel=110 → op2=0, out_valid=1, sel_err=1 and stays 1 through later legal beats until rst.
- With OP2_FWD_COUNT_EN: 4 forwarded beats plus 1 forwarded beat flushed → fwd_count=4. Without the macro → fwd_count=0.
